fpu_issue: RTL and testbench
============================

FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 `clk  in  1  rising-edge clock`
REQ-003 `rst  in  1  synchronous, active-low reset`
REQ-004 `id_valid  in  1  decode presents an FP add/sub`
REQ-005 `id_ready  out  1  issue accepts this cycle`
REQ-006 `id_op  in  1  0 = FADD, 1 = FSUB (same encoding as FALUCtrl)`
REQ-007 `id_rs1, id_rs2, id_rd  in  5 each  FP register indices`
REQ-008 `ex_valid  out  1  operand stage holds a valid op`
REQ-009 `ex_ready  in  1  FP ALU stage accepts`
REQ-010 `ex_rs1_val, ex_rs2_val  out  32 each  IEEE-754 single operands`
REQ-011 `ex_falu_ctrl  out  1  op to FP ALU`
REQ-012 `ex_rd  out  5  destination index`
REQ-013 `wb_en  in  1  FP writeback strobe`
REQ-014 `wb_rd  in  5  writeback index`
REQ-015 `wb_data  in  32  writeback value`
REQ-016 `flush  in  1  kill the op held in the operand stage`
REQ-017 `sb_busy  out  32  scoreboard pending bits, for debug`

Function
REQ-018 The block SHALL hold a 32x32 FP register file with two read ports and one write port; f0 SHALL be a normal writable register.
REQ-019 A write with wb_en=1 SHALL update regfile[wb_rd] at the clock edge.
REQ-020 A read port SHALL return wb_data when wb_en=1 and wb_rd equals the read index in the same cycle, giving a write-to-read bypass.
REQ-021 The scoreboard SHALL be a 32-bit vector; a bit is set when an op with that rd is accepted and cleared when wb_en=1 with that wb_rd.
REQ-022 A scoreboard bit being cleared by writeback in the current cycle SHALL count as not busy.
REQ-023 hazard SHALL be `sb[rs1] | sb[rs2] | sb[rd]`, evaluated after the REQ-022 clear.
REQ-024 id_ready SHALL be `!hazard & !flush & (!ex_valid | ex_ready)`.
REQ-025 On acceptance (id_valid & id_ready), the bypassed operands, op and rd SHALL be latched into the ex_* registers and ex_valid set to 1 at the next edge, giving 1-cycle latency.
REQ-026 When `ex_valid & ex_ready` and no new acceptance occurs, ex_valid SHALL go to 0 and ex_* data SHALL hold.
REQ-027 ex_* outputs SHALL be stable while `ex_valid & !ex_ready`, per the valid/ready rule.
REQ-028 Same-cycle set and clear of one scoreboard bit SHALL result in set.
REQ-029 On flush=1, ex_valid SHALL go to 0 next edge, and if ex_valid=1 and ex_ready=0, sb[ex_rd] SHALL be cleared.
REQ-030 Ops already handed to the ALU SHALL keep their scoreboard bits through a flush.
REQ-031 sb_busy SHALL present the registered scoreboard.

Reset
REQ-032 While rst=0 at a clock edge, all of the following SHALL be cleared: every regfile entry to 32'h0, the scoreboard to 0, ex_valid to 0, and ex_rs1_val, ex_rs2_val, ex_falu_ctrl and ex_rd to 0.
REQ-033 id_ready SHALL be 0 while rst=0.
REQ-034 Reset mid-operation SHALL discard the in-flight op, and all pending bits SHALL be lost.

Structure
REQ-035 Package fpu_pkg SHALL hold the op encoding constants (FADD=1'b0, FSUB=1'b1), the FP register index type (5 bits) and the register count (32).
REQ-036 The register file SHALL be the sub-module fp_regfile (2R/1W with bypass); scoreboard, handshake and operand stage SHALL stay in fpu_issue.

Verification
REQ-037 Write wb f3=32'h3F800000 and f4=32'h40000000, then issue FADD rs1=3 rs2=4 rd=5 -> next cycle ex_valid=1, ex_rs1_val=32'h3F800000, ex_rs2_val=32'h40000000, ex_falu_ctrl=0, ex_rd=5, sb_busy[5]=1.
REQ-038 Issue rd=5, then next op with rs1=5 -> id_ready=0. Drive wb_en with wb_rd=5, wb_data=32'h40400000 -> same cycle id_ready=1, and the latched ex_rs1_val is 32'h40400000 via bypass.
REQ-039 Hold ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable and id_ready=0. Raise ex_ready with id_valid=1 -> back-to-back acceptance, with ex_valid staying 1.
REQ-040 ex_valid=1, ex_ready=0, ex_rd=7, assert flush -> next cycle ex_valid=0 and sb_busy[7]=0. A flush after the handshake leaves sb_busy[7]=1.
REQ-041 Pull rst=0 with ex_valid=1 and sb_busy=32'h00000020 -> next edge all outputs 0 and regfile reads 0.
REQ-042 Same cycle: wb clears rd=9 while a new op with rd=9 is accepted -> sb_busy[9]=1 afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue slice: op encoding, register index type
// and register count.
package fpu_pkg;

  localparam int NUM_REGS = 32;

  localparam logic FADD = 1'b0;
  localparam logic FSUB = 1'b1;

  typedef logic [4:0] freg_idx_t;

endpackage

// File: rtl/fp_regfile.sv
// 32x32 FP register file, two combinational read ports and one write port.
// A write in flight is forwarded to any read of the same index in that cycle.
module fp_regfile
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  freg_idx_t   rd_idx_a,
  output logic [31:0] rd_data_a,
  input  freg_idx_t   rd_idx_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  freg_idx_t   wr_idx,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [NUM_REGS];

  // f0 is an ordinary register here, so no index is special-cased
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = (wr_en && (wr_idx == rd_idx_a)) ? wr_data : regs[rd_idx_a];
    rd_data_b = (wr_en && (wr_idx == rd_idx_b)) ? wr_data : regs[rd_idx_b];
  end

endmodule

// File: rtl/fpu_issue.sv
// FP add/sub issue stage: scoreboarded hazard check, operand read with
// writeback bypass, and a single valid/ready operand register toward the ALU.
module fpu_issue
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic        id_op,
  input  freg_idx_t   id_rs1,
  input  freg_idx_t   id_rs2,
  input  freg_idx_t   id_rd,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic        ex_falu_ctrl,
  output freg_idx_t   ex_rd,
  input  logic        wb_en,
  input  freg_idx_t   wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic [31:0] sb_busy
);

  logic [31:0] sb;
  logic [31:0] wb_clr;
  logic [31:0] flush_clr;
  logic [31:0] acc_set;
  logic [31:0] sb_eff;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        hazard;
  logic        accept;

  fp_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_a  (id_rs1),
    .rd_data_a (rs1_val),
    .rd_idx_b  (id_rs2),
    .rd_data_b (rs2_val),
    .wr_en     (wb_en),
    .wr_idx    (wb_rd),
    .wr_data   (wb_data)
  );

  // A bit retiring this cycle already counts as free for the hazard check
  always_comb begin
    wb_clr    = wb_en ? (32'd1 << wb_rd) : 32'd0;
    flush_clr = (flush && ex_valid && !ex_ready) ? (32'd1 << ex_rd) : 32'd0;
    sb_eff    = sb & ~wb_clr;
    hazard    = sb_eff[id_rs1] | sb_eff[id_rs2] | sb_eff[id_rd];
    id_ready  = rst & !hazard & !flush & (!ex_valid | ex_ready);
    accept    = id_valid & id_ready;
    acc_set   = accept ? (32'd1 << id_rd) : 32'd0;
  end

  // Setting wins over any clear of the same bit in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      sb <= 32'd0;
    end else begin
      sb <= (sb & ~wb_clr & ~flush_clr) | acc_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_rs1_val   <= 32'h0;
      ex_rs2_val   <= 32'h0;
      ex_falu_ctrl <= FADD;
      ex_rd        <= '0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_rs1_val   <= rs1_val;
      ex_rs2_val   <= rs2_val;
      ex_falu_ctrl <= id_op;
      ex_rd        <= id_rd;
    end else if (flush || ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign sb_busy = sb;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed self-checking bench for fpu_issue; inputs change on the falling
// edge, registered outputs are sampled 1 ns after the rising edge.
module tb_fpu_issue;
  import fpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic        id_op;
  freg_idx_t   id_rs1;
  freg_idx_t   id_rs2;
  freg_idx_t   id_rd;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic        ex_falu_ctrl;
  freg_idx_t   ex_rd;
  logic        wb_en;
  freg_idx_t   wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] sb_busy;

  int total;
  int passed;

  fpu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_op        (id_op),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_falu_ctrl (ex_falu_ctrl),
    .ex_rd        (ex_rd),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .sb_busy      (sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic op, input int rs1, input int rs2, input int rd);
    id_valid = v;
    id_op    = op;
    id_rs1   = freg_idx_t'(rs1);
    id_rs2   = freg_idx_t'(rs2);
    id_rd    = freg_idx_t'(rd);
  endtask

  task automatic drive_wb(input logic en, input int rd, input logic [31:0] data);
    wb_en   = en;
    wb_rd   = freg_idx_t'(rd);
    wb_data = data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_op(1'b1, FADD, 1, 2, 3);
    #1;
    total++;
    if (id_ready !== 1'b0) $display("[TB] FAIL reset_id_ready got %b want 0", id_ready);
    else passed++;
    tick();
    total++;
    if (ex_valid !== 1'b0 || sb_busy !== 32'h0 || ex_rd !== 5'd0 || ex_rs1_val !== 32'h0)
      $display("[TB] FAIL reset_state got v=%b sb=%h rd=%0d rs1=%h want 0", ex_valid, sb_busy, ex_rd, ex_rs1_val);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic test_issue();
    @(negedge clk);
    drive_wb(1'b1, 3, 32'h3F800000);
    tick();
    @(negedge clk);
    drive_wb(1'b1, 4, 32'h40000000);
    tick();
    @(negedge clk);
    drive_wb(1'b0, 0, 32'h0);
    ex_ready = 1'b1;
    drive_op(1'b1, FADD, 3, 4, 5);
    #1;
    total++;
    if (id_ready !== 1'b1) $display("[TB] FAIL issue_id_ready got %b want 1", id_ready);
    else passed++;
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_rs1_val !== 32'h3F800000 || ex_rs2_val !== 32'h40000000 ||
        ex_falu_ctrl !== 1'b0 || ex_rd !== 5'd5)
      $display("[TB] FAIL issue_ex got v=%b a=%h b=%h op=%b rd=%0d want 1 3f800000 40000000 0 5",
               ex_valid, ex_rs1_val, ex_rs2_val, ex_falu_ctrl, ex_rd);
    else passed++;
    total++;
    if (sb_busy !== 32'h00000020) $display("[TB] FAIL issue_sb got %h want 00000020", sb_busy);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    tick();
    total++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd5) $display("[TB] FAIL drain_hold got v=%b rd=%0d want 0 5", ex_valid, ex_rd);
    else passed++;
  endtask

  task automatic test_hazard();
    @(negedge clk);
    drive_op(1'b1, FSUB, 5, 4, 6);
    #1;
    total++;
    if (id_ready !== 1'b0) $display("[TB] FAIL raw_hazard got %b want 0", id_ready);
    else passed++;
    drive_wb(1'b1, 5, 32'h40400000);
    #1;
    total++;
    if (id_ready !== 1'b1) $display("[TB] FAIL wb_release got %b want 1", id_ready);
    else passed++;
    tick();
    total++;
    if (ex_rs1_val !== 32'h40400000 || ex_rs2_val !== 32'h40000000 || ex_falu_ctrl !== 1'b1 || ex_rd !== 5'd6)
      $display("[TB] FAIL bypass got a=%h b=%h op=%b rd=%0d want 40400000 40000000 1 6",
               ex_rs1_val, ex_rs2_val, ex_falu_ctrl, ex_rd);
    else passed++;
    total++;
    if (sb_busy !== 32'h00000040) $display("[TB] FAIL bypass_sb got %h want 00000040", sb_busy);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    drive_wb(1'b1, 6, 32'h40800000);
    tick();
    @(negedge clk);
    drive_wb(1'b0, 0, 32'h0);
    total++;
    if (sb_busy !== 32'h0) $display("[TB] FAIL sb_clear got %h want 0", sb_busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex_ready = 1'b0;
    drive_op(1'b1, FADD, 3, 4, 8);
    tick();
    @(negedge clk);
    drive_op(1'b1, FSUB, 3, 4, 10);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (id_ready !== 1'b0) $display("[TB] FAIL stall_ready[%0d] got %b want 0", i, id_ready);
      else passed++;
      tick();
      total++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || ex_rs1_val !== 32'h3F800000 || ex_falu_ctrl !== 1'b0)
        $display("[TB] FAIL stall_hold[%0d] got v=%b rd=%0d a=%h op=%b want 1 8 3f800000 0",
                 i, ex_valid, ex_rd, ex_rs1_val, ex_falu_ctrl);
      else passed++;
      @(negedge clk);
    end
    ex_ready = 1'b1;
    #1;
    total++;
    if (id_ready !== 1'b1) $display("[TB] FAIL b2b_ready got %b want 1", id_ready);
    else passed++;
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_falu_ctrl !== 1'b1 || sb_busy !== 32'h00000500)
      $display("[TB] FAIL b2b_ex got v=%b rd=%0d op=%b sb=%h want 1 10 1 00000500",
               ex_valid, ex_rd, ex_falu_ctrl, sb_busy);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    drive_wb(1'b1, 8, 32'h0);
    tick();
    @(negedge clk);
    drive_wb(1'b1, 10, 32'h0);
    tick();
    @(negedge clk);
    drive_wb(1'b0, 0, 32'h0);
    total++;
    if (sb_busy !== 32'h0 || ex_valid !== 1'b0) $display("[TB] FAIL b2b_drain got sb=%h v=%b want 0 0", sb_busy, ex_valid);
    else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    ex_ready = 1'b0;
    drive_op(1'b1, FADD, 3, 4, 7);
    tick();
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    flush = 1'b1;
    #1;
    total++;
    if (id_ready !== 1'b0) $display("[TB] FAIL flush_ready got %b want 0", id_ready);
    else passed++;
    tick();
    total++;
    if (ex_valid !== 1'b0 || sb_busy[7] !== 1'b0) $display("[TB] FAIL flush_kill got v=%b sb7=%b want 0 0", ex_valid, sb_busy[7]);
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    ex_ready = 1'b1;
    drive_op(1'b1, FADD, 3, 4, 7);
    tick();
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    flush = 1'b1;
    tick();
    total++;
    if (ex_valid !== 1'b0 || sb_busy[7] !== 1'b1) $display("[TB] FAIL flush_after_hs got v=%b sb7=%b want 0 1", ex_valid, sb_busy[7]);
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    drive_wb(1'b1, 7, 32'h0);
    tick();
    @(negedge clk);
    drive_wb(1'b0, 0, 32'h0);
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    drive_op(1'b1, FADD, 3, 4, 9);
    tick();
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    tick();
    @(negedge clk);
    drive_wb(1'b1, 9, 32'h41000000);
    drive_op(1'b1, FSUB, 3, 4, 9);
    #1;
    total++;
    if (id_ready !== 1'b1) $display("[TB] FAIL set_clr_ready got %b want 1", id_ready);
    else passed++;
    tick();
    total++;
    if (sb_busy !== 32'h00000200 || ex_rd !== 5'd9) $display("[TB] FAIL set_clr_sb got sb=%h rd=%0d want 00000200 9", sb_busy, ex_rd);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    drive_wb(1'b1, 9, 32'h0);
    tick();
    @(negedge clk);
    drive_wb(1'b0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_ready = 1'b0;
    drive_op(1'b1, FADD, 3, 4, 5);
    tick();
    total++;
    if (sb_busy !== 32'h00000020 || ex_valid !== 1'b1) $display("[TB] FAIL pre_reset got sb=%h v=%b want 00000020 1", sb_busy, ex_valid);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    rst = 1'b0;
    tick();
    total++;
    if (ex_valid !== 1'b0 || sb_busy !== 32'h0 || ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h0 ||
        ex_falu_ctrl !== 1'b0 || ex_rd !== 5'd0 || id_ready !== 1'b0)
      $display("[TB] FAIL mid_reset got v=%b sb=%h a=%h b=%h op=%b rd=%0d rdy=%b want all 0",
               ex_valid, sb_busy, ex_rs1_val, ex_rs2_val, ex_falu_ctrl, ex_rd, id_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    ex_ready = 1'b1;
    drive_op(1'b1, FADD, 3, 5, 1);
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h0)
      $display("[TB] FAIL rf_cleared got v=%b a=%h b=%h want 1 0 0", ex_valid, ex_rs1_val, ex_rs2_val);
    else passed++;
  endtask

  task automatic test_f0();
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    drive_wb(1'b1, 0, 32'h12345678);
    tick();
    @(negedge clk);
    drive_wb(1'b1, 1, 32'h0);
    drive_op(1'b1, FSUB, 0, 0, 2);
    tick();
    total++;
    if (ex_rs1_val !== 32'h12345678 || ex_rs2_val !== 32'h12345678 || ex_rd !== 5'd2)
      $display("[TB] FAIL f0_write got a=%h b=%h rd=%0d want 12345678 12345678 2", ex_rs1_val, ex_rs2_val, ex_rd);
    else passed++;
    @(negedge clk);
    drive_op(1'b0, FADD, 0, 0, 0);
    drive_wb(1'b0, 0, 32'h0);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    rst      = 1'b0;
    ex_ready = 1'b0;
    flush    = 1'b0;
    drive_op(1'b0, FADD, 0, 0, 0);
    drive_wb(1'b0, 0, 32'h0);
    repeat (2) @(posedge clk);
    test_reset();
    test_issue();
    test_hazard();
    test_back_to_back();
    test_flush();
    test_same_cycle();
    test_reset_mid();
    test_f0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
